// File: rtl/pnc_stmc_dispatch.sv
// Expands one accepted address word into neuron-array beats (spike, dual spike, param write, rich-club broadcast) or drops it.
// Latency: first beat valid 2 posedges after acceptance; back-to-back beats at 1 per cycle while o_ready is high.
// Backpressure: in_ready only in IDLE; a beat holds stable while o_valid && !o_ready.
module pnc_stmc_dispatch #(
    parameter int N_NEURON = 128,
    parameter int ADDR_W   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       iAddr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        ctrl,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [ADDR_W-1:0] o_addr,
    output logic [1:0]        o_kind,
    output logic [7:0]        o_data,
    output logic              busy,
    output logic [7:0]        drop_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_PARAM,
        S_SEND1,
        S_SEND2,
        S_BCAST
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_NEURON = ADDR_W'(N_NEURON - 1);
    localparam logic [1:0] KIND_SPIKE = 2'b00;
    localparam logic [1:0] KIND_PARAM = 2'b01;
    localparam logic [1:0] KIND_RICH  = 2'b10;

    state_t            state_q, state_d;
    logic [15:0]       word_q, word_d;
    logic              dual_q, dual_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [7:0]        drop_q, drop_d;
    logic              o_valid_q, o_valid_d;
    logic [ADDR_W-1:0] o_addr_q, o_addr_d;
    logic [1:0]        o_kind_q, o_kind_d;
    logic [7:0]        o_data_q, o_data_d;

    assign in_ready = (state_q == S_IDLE) && !rst;
    assign busy     = (state_q != S_IDLE);
    assign drop_cnt = drop_q;
    assign o_valid  = o_valid_q;
    assign o_addr   = o_addr_q;
    assign o_kind   = o_kind_q;
    assign o_data   = o_data_q;

    // State, latched word, broadcast counter and output beat registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            word_q    <= '0;
            dual_q    <= 1'b0;
            cnt_q     <= '0;
            drop_q    <= '0;
            o_valid_q <= 1'b0;
            o_addr_q  <= '0;
            o_kind_q  <= '0;
            o_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            dual_q    <= dual_d;
            cnt_q     <= cnt_d;
            drop_q    <= drop_d;
            o_valid_q <= o_valid_d;
            o_addr_q  <= o_addr_d;
            o_kind_q  <= o_kind_d;
            o_data_q  <= o_data_d;
        end
    end

    // Next state; ctrl is only trusted in DECODE, when it reflects word_q.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        dual_d  = dual_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    word_d  = iAddr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (ctrl)
                    2'b00: begin
                        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                        state_d = S_IDLE;
                    end
                    2'b01: begin
                        dual_d  = 1'b0;
                        state_d = word_q[15] ? S_PARAM : S_SEND1;
                    end
                    2'b11: begin
                        dual_d  = 1'b1;
                        state_d = S_SEND1;
                    end
                    default: begin
                        cnt_d   = '0;
                        state_d = S_BCAST;
                    end
                endcase
            end
            S_PARAM: begin
                if (o_ready) state_d = S_IDLE;
            end
            S_SEND1: begin
                if (o_ready) state_d = dual_q ? S_SEND2 : S_IDLE;
            end
            S_SEND2: begin
                if (o_ready) state_d = S_IDLE;
            end
            S_BCAST: begin
                if (o_ready) begin
                    if (cnt_q == LAST_NEURON) state_d = S_IDLE;
                    else                      cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Beat registers follow the next state, so a stalled beat re-registers identical values.
    always_comb begin
        o_valid_d = 1'b0;
        o_addr_d  = '0;
        o_kind_d  = KIND_SPIKE;
        o_data_d  = '0;
        case (state_d)
            S_PARAM: begin
                o_valid_d = 1'b1;
                o_kind_d  = KIND_PARAM;
                o_addr_d  = word_d[ADDR_W-1:0];
                o_data_d  = word_d[14:7];
            end
            S_SEND1: begin
                o_valid_d = 1'b1;
                o_addr_d  = word_d[ADDR_W-1:0];
            end
            S_SEND2: begin
                o_valid_d = 1'b1;
                o_addr_d  = word_d[2*ADDR_W-1:ADDR_W];
            end
            S_BCAST: begin
                o_valid_d = 1'b1;
                o_kind_d  = KIND_RICH;
                o_addr_d  = cnt_d;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pnc_stmc_dispatch.sv
// Directed bench for pnc_stmc_dispatch with an 8-neuron rich club.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// ctrl is driven by the bench in the DECODE cycle, standing in for the control unit.
module tb_pnc_stmc_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] iAddr;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  ctrl;
    logic        o_valid;
    logic        o_ready;
    logic [6:0]  o_addr;
    logic [1:0]  o_kind;
    logic [7:0]  o_data;
    logic        busy;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    pnc_stmc_dispatch #(.N_NEURON(8), .ADDR_W(7)) dut (
        .clk      (clk),
        .rst      (rst),
        .iAddr    (iAddr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ctrl     (ctrl),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_addr   (o_addr),
        .o_kind   (o_kind),
        .o_data   (o_data),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a word for one cycle, then drive the matching ctrl for the DECODE cycle.
    task automatic offer(input logic [15:0] w, input logic [1:0] c);
        iAddr    = w;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        iAddr    = 16'hFFFF;
        ctrl     = c;
    endtask

    int exp_drop;
    logic saw_valid;

    initial begin
        rst = 1'b1; iAddr = '0; in_valid = 1'b0; ctrl = 2'b00; o_ready = 1'b0;
        step();
        step();
        check("rst_o_valid", o_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_o_addr", o_addr, 0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1);

        // Single spike.
        o_ready = 1'b1;
        offer(16'h0005, 2'b01);
        check("s_busy_decode", busy, 1);
        check("s_in_ready_decode", in_ready, 0);
        check("s_no_valid_decode", o_valid, 0);
        step();
        check("s_valid", o_valid, 1);
        check("s_kind", o_kind, 2'b00);
        check("s_addr", o_addr, 5);
        check("s_data", o_data, 0);
        ctrl = 2'b10;
        step();
        check("s_done_valid", o_valid, 0);
        check("s_done_in_ready", in_ready, 1);

        // Dual spike, first beat stalled three cycles.
        o_ready = 1'b0;
        offer(16'h0203, 2'b11);
        step();
        check("d_valid1", o_valid, 1);
        check("d_addr1", o_addr, 3);
        ctrl = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            check("d_hold_valid", o_valid, 1);
            check("d_hold_addr", o_addr, 3);
            check("d_hold_kind", o_kind, 2'b00);
        end
        o_ready = 1'b1;
        step();
        check("d_valid2", o_valid, 1);
        check("d_addr2", o_addr, 4);
        step();
        check("d_done_valid", o_valid, 0);
        check("d_done_busy", busy, 0);

        // Parameter write.
        offer(16'hAA0A, 2'b01);
        step();
        check("p_valid", o_valid, 1);
        check("p_kind", o_kind, 2'b01);
        check("p_addr", o_addr, 10);
        check("p_data", o_data, 8'h54);
        check("p_drop", drop_cnt, 0);
        step();
        check("p_done_valid", o_valid, 0);

        // Rich-club broadcast over 8 neurons.
        offer(16'h4000, 2'b10);
        for (int k = 0; k < 8; k++) begin
            step();
            ctrl = 2'b01;
            check("b_valid", o_valid, 1);
            check("b_kind", o_kind, 2'b10);
            check("b_addr", o_addr, k);
            check("b_in_ready", in_ready, 0);
        end
        step();
        check("b_done_valid", o_valid, 0);
        check("b_done_busy", busy, 0);

        // 300 null words: counter saturates, no beats.
        exp_drop  = 0;
        saw_valid = 1'b0;
        for (int n = 0; n < 300; n++) begin
            offer(16'h0000, 2'b00);
            if (o_valid) saw_valid = 1'b1;
            step();
            if (o_valid) saw_valid = 1'b1;
            if (exp_drop < 255) exp_drop++;
            check("n_drop", drop_cnt, exp_drop);
        end
        check("n_no_valid", saw_valid, 0);
        check("n_drop_sat", drop_cnt, 255);

        // Reset in the middle of a broadcast.
        offer(16'h4000, 2'b10);
        for (int k = 0; k < 4; k++) step();
        check("r_addr_before", o_addr, 3);
        rst = 1'b1;
        step();
        check("r_valid", o_valid, 0);
        check("r_busy", busy, 0);
        check("r_drop", drop_cnt, 0);
        check("r_in_ready", in_ready, 0);
        rst = 1'b0;
        offer(16'h0001, 2'b01);
        step();
        check("r_s_valid", o_valid, 1);
        check("r_s_addr", o_addr, 1);
        check("r_s_kind", o_kind, 2'b00);
        step();
        check("r_s_done", o_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pnc_stmc_dispatch.md
Name: pnc_stmc_dispatch

Overview:
- Downstream stage of the STMC control unit.
- Accepts one 16-bit input address word per handshake, pairs it with the 2-bit ctrl the control unit registers from that same word, and expands it into per-neuron access beats toward the physical neuron array.
- Beat types: single spike, dual spike, parameter write, rich-club broadcast, or drop.
- Owns input backpressure, so the control unit's registered decode never desynchronises from the word being dispatched.

Parameters:
- N_NEURON, 128, number of local neurons; rich-club broadcast covers addresses 0..N_NEURON-1 (2..128).
- ADDR_W, 7, neuron address width.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- iAddr  input  16  input address word; same bus also drives the control unit
- in_valid  input  1  iAddr holds a valid word
- in_ready  output  1  dispatcher can accept a word
- ctrl  input  2  control unit decode, valid the cycle after acceptance
- o_valid  output  1  beat valid toward neuron array
- o_ready  input  1  neuron array accepts beat
- o_addr  output  ADDR_W  target neuron
- o_kind  output  2  00 local spike, 01 param write, 10 rich-club spike
- o_data  output  8  param value (iAddr[14:7] of latched word); 0 for spikes
- busy  output  1  state != IDLE
- drop_cnt  output  8  count of null words, saturates at 255

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=IDLE; o_valid=0, o_addr=0, o_kind=0, o_data=0, drop_cnt=0, latched word=0, broadcast counter=0.
  - Reset mid-operation abandons any beat or broadcast immediately.
  - in_ready=0 while rst=1.
- in_ready = (state==IDLE) && !rst. Handshake completes at a posedge with in_valid && in_ready; the word is latched into word_q and state goes to DECODE.
- DECODE (exactly 1 cycle): ctrl reflects word_q because the control unit registered the same iAddr at the acceptance edge. in_ready=0. At the next posedge:
  - ctrl=00: drop_cnt += 1 (saturating) -> IDLE.
  - ctrl=01, word_q[15]=1: -> PARAM.
  - ctrl=01, word_q[15]=0: -> SEND1, single beat.
  - ctrl=11: -> SEND1, then SEND2.
  - ctrl=10: -> BCAST, counter=0.
- PARAM: o_valid=1, o_kind=01, o_addr=word_q[6:0], o_data=word_q[14:7]. On o_ready -> IDLE.
- SEND1: o_valid=1, o_kind=00, o_addr=word_q[6:0]. Address 0 is issued as-is. On o_ready -> SEND2 if dual, else IDLE.
- SEND2: o_valid=1, o_kind=00, o_addr=word_q[13:7]. On o_ready -> IDLE.
- BCAST: o_valid=1, o_kind=10, o_addr=counter.
  - On o_ready: if counter==N_NEURON-1 -> IDLE, else counter+1.
  - Counter never wraps past N_NEURON-1.
- Output registers: o_valid, o_addr, o_kind and o_data are registered and change only at posedges. A beat holds stable while o_valid && !o_ready (AXI-style: no retraction, no change).
- Latency: acceptance edge -> first o_valid high after 2 posedges (acceptance, DECODE exit). Back-to-back beats take 1 cycle each when o_ready=1.
- Minimum inter-word spacing: 3 cycles for a single beat, 4 for dual, N_NEURON+2 for broadcast.
- iAddr changes while in_ready=0 are ignored. The control unit's ctrl is consulted only in DECODE.
- Unused ctrl/word combinations are impossible by construction of the control unit; no error path.

Test Plan:
- Single spike: iAddr=16'h0005, in_valid 1 cycle, o_ready=1 -> one beat o_kind=00, o_addr=5, o_valid 2 posedges after acceptance; in_ready returns 1 the cycle after the beat.
- Dual spike with backpressure: iAddr=16'h0183 (2nd=3, 1st=3 -> use 16'h0203: 2nd=4, 1st=3), o_ready low 3 cycles on the first beat -> o_addr=3 held stable 4 cycles, then o_addr=4, then IDLE.
- Param write: iAddr=16'hAA0A -> o_kind=01, o_addr=10, o_data=8'h54; drop_cnt unchanged.
- Rich-club broadcast (N_NEURON=8): iAddr=16'h4000, o_ready=1 -> 8 beats o_kind=10, o_addr 0..7 on consecutive cycles; busy falls after the last beat; in_ready=0 throughout.
- Null words: 300 words of 16'h0000 -> no o_valid; drop_cnt saturates at 255.
- Reset mid-broadcast: assert rst at beat o_addr=3 -> next cycle o_valid=0, busy=0, drop_cnt=0; a following single spike 16'h0001 dispatches normally.
